// File: rtl/uart_rx_fifo.sv
// UART receiver with run-time frame configuration, 3-sample majority voting,
// per-word parity/framing/break flags and a first-word fall-through output FIFO.
module uart_rx_fifo #(
  parameter int unsigned FREQ_CLK   = 100_000_000,
  parameter int unsigned DATA_WDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DEF_BAUD   = 115200
) (
  input  logic                               CLKip,
  input  logic                               RSTi,
  input  logic                               RXi,
  input  logic                               CFG_WEi,
  input  logic [15:0]                        BAUD_DIVi,
  input  logic [1:0]                         PARITY_MODEi,
  input  logic                               STOP2i,
  input  logic                               READYi,
  output logic [DATA_WDTH-1:0]               DATAo,
  output logic                               VALIDo,
  output logic                               PERRo,
  output logic                               FERRo,
  output logic                               BRKo,
  output logic                               OVRo,
  output logic                               BUSYo,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_CNTo
);
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned WORD_W  = DATA_WDTH + 3;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned BIT_W   = $clog2(DATA_WDTH);
  localparam int unsigned MIN_DIV = 4;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(FREQ_CLK / DEF_BAUD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0]     div, half, bc, bc_n;
  logic [1:0]           par_mode;
  logic                 stop2;
  logic [BIT_W-1:0]     bit_idx, bit_idx_n;
  logic                 stop_idx, stop_idx_n;
  logic                 smp_a, smp_a_n, smp_b, smp_b_n;
  logic                 vote, decide, par_en;
  logic [DATA_WDTH-1:0] shreg, shreg_n;
  logic                 perr, perr_n, ferr, ferr_n, brk, brk_n;
  logic                 wr_req, wr_req_n;
  logic [WORD_W-1:0]    wr_word, wr_word_n;

  logic [WORD_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]     cnt, cnt_n, remain;
  logic [WORD_W-1:0]    head, head_n;
  logic                 valid, ovr, busy, pop, full, do_wr;

  assign half   = div >> 1;
  assign decide = (bc == DIV_W'(half + DIV_W'(1)));
  assign vote   = (smp_a & smp_b) | (smp_a & rx_sync) | (smp_b & rx_sync);
  assign par_en = (par_mode == 2'b01) || (par_mode == 2'b10);

  // Receiver registers: synchroniser, configuration, frame FSM and accumulators.
  always_ff @(posedge CLKip) begin
    if (RSTi) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      div      <= DEF_DIV;
      par_mode <= 2'b00;
      stop2    <= 1'b0;
      state    <= IDLE;
      bc       <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      smp_a    <= 1'b1;
      smp_b    <= 1'b1;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      brk      <= 1'b0;
      wr_req   <= 1'b0;
      wr_word  <= '0;
      busy     <= 1'b0;
    end else begin
      rx_meta <= RXi;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (CFG_WEi && state == IDLE) begin
        div      <= (BAUD_DIVi < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : BAUD_DIVi;
        par_mode <= PARITY_MODEi;
        stop2    <= STOP2i;
      end
      state    <= state_n;
      bc       <= bc_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      smp_a    <= smp_a_n;
      smp_b    <= smp_b_n;
      shreg    <= shreg_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
      brk      <= brk_n;
      wr_req   <= wr_req_n;
      wr_word  <= wr_word_n;
      busy     <= (state_n != IDLE);
    end
  end

  // The start-detect cycle counts as bc 0, so the first START cycle is bc 1.
  always_comb begin
    state_n    = state;
    bc_n       = (bc == DIV_W'(div - DIV_W'(1))) ? '0 : DIV_W'(bc + DIV_W'(1));
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    smp_a_n    = (bc == DIV_W'(half - DIV_W'(1))) ? rx_sync : smp_a;
    smp_b_n    = (bc == half) ? rx_sync : smp_b;
    shreg_n    = shreg;
    perr_n     = perr;
    ferr_n     = ferr;
    brk_n      = brk;
    wr_req_n   = 1'b0;
    wr_word_n  = wr_word;
    case (state)
      IDLE: begin
        bc_n = '0;
        if (!rx_sync && rx_prev) begin
          state_n    = START;
          bc_n       = DIV_W'(1);
          bit_idx_n  = '0;
          stop_idx_n = 1'b0;
          perr_n     = 1'b0;
          ferr_n     = 1'b0;
          brk_n      = 1'b1;
        end
      end
      START: begin
        if (decide) state_n = vote ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shreg_n = {vote, shreg[DATA_WDTH-1:1]};
          brk_n   = brk & ~vote;
          if (bit_idx == BIT_W'(DATA_WDTH - 1)) state_n = par_en ? PARITY : STOP;
          else bit_idx_n = BIT_W'(bit_idx + BIT_W'(1));
        end
      end
      PARITY: begin
        if (decide) begin
          brk_n   = brk & ~vote;
          perr_n  = (((^shreg) ^ vote) != (par_mode == 2'b10));
          state_n = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          ferr_n = ferr | ~vote;
          if (!stop_idx) brk_n = brk & ~vote;
          if (!stop2 || stop_idx) begin
            state_n   = IDLE;
            wr_req_n  = 1'b1;
            wr_word_n = {brk_n, ferr_n, perr, shreg};
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO control; the head register is preloaded so the front word falls through.
  always_comb begin
    pop      = valid & READYi;
    full     = (cnt == CNT_W'(FIFO_DEPTH));
    do_wr    = wr_req & (~full | pop);
    rd_ptr_n = pop ? PTR_W'(rd_ptr + PTR_W'(1)) : rd_ptr;
    remain   = pop ? CNT_W'(cnt - CNT_W'(1)) : cnt;
    cnt_n    = do_wr ? CNT_W'(remain + CNT_W'(1)) : remain;
    head_n   = '0;
    if (remain == '0) head_n = do_wr ? wr_word : '0;
    else head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge CLKip) begin
    if (RSTi) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
      valid  <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      rd_ptr <= rd_ptr_n;
      cnt    <= cnt_n;
      head   <= head_n;
      valid  <= (cnt_n != '0);
      ovr    <= wr_req & full & ~pop;
    end
  end

  always_ff @(posedge CLKip) begin
    if (do_wr) mem[wr_ptr] <= wr_word;
  end

  assign DATAo     = head[DATA_WDTH-1:0];
  assign PERRo     = head[DATA_WDTH];
  assign FERRo     = head[DATA_WDTH+1];
  assign BRKo      = head[DATA_WDTH+2];
  assign VALIDo    = valid;
  assign OVRo      = ovr;
  assign BUSYo     = busy;
  assign FIFO_CNTo = cnt;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frame table, multi-cycle corner sequences and
// randomized frames scored against a behavioural word model and FIFO queue.
module tb_uart_rx_fifo;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          DEFD  = 868;

  logic        CLKip = 1'b0;
  logic        RSTi, RXi, CFG_WEi, STOP2i, READYi;
  logic [15:0] BAUD_DIVi;
  logic [1:0]  PARITY_MODEi;
  logic [W-1:0] DATAo;
  logic        VALIDo, PERRo, FERRo, BRKo, OVRo, BUSYo;
  logic [2:0]  FIFO_CNTo;

  always #5 CLKip = ~CLKip;

  uart_rx_fifo #(.FREQ_CLK(100_000_000), .DATA_WDTH(W), .FIFO_DEPTH(DEPTH), .DEF_BAUD(115200)) dut (
    .CLKip(CLKip), .RSTi(RSTi), .RXi(RXi), .CFG_WEi(CFG_WEi), .BAUD_DIVi(BAUD_DIVi),
    .PARITY_MODEi(PARITY_MODEi), .STOP2i(STOP2i), .READYi(READYi), .DATAo(DATAo),
    .VALIDo(VALIDo), .PERRo(PERRo), .FERRo(FERRo), .BRKo(BRKo), .OVRo(OVRo),
    .BUSYo(BUSYo), .FIFO_CNTo(FIFO_CNTo));

  typedef struct packed {logic brk; logic ferr; logic perr; logic [W-1:0] data;} word_t;
  typedef struct {
    logic [1:0] pm; logic st2; logic [W-1:0] d; logic pb; logic s1; logic s2;
    logic [W-1:0] e_d; logic e_perr; logic e_ferr; logic e_brk;
  } vec_t;

  int    n_total = 0;
  int    n_pass  = 0;
  int    ovr_cycles = 0;
  logic  tx_bits[$];
  word_t exp_q[$];
  vec_t  vecs[10];

  always @(negedge CLKip) if (OVRo) ovr_cycles++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected word from the frame contents alone.
  function automatic word_t model(input logic [1:0] pm, input logic [W-1:0] d, input logic pb,
                                  input logic st2, input logic s1, input logic s2);
    word_t w;
    bit    par_on;
    int    ones;
    par_on = (pm == 2'b01) || (pm == 2'b10);
    ones   = $countones(d) + ((par_on && pb) ? 1 : 0);
    w.data = d;
    w.perr = par_on && ((pm == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0));
    w.ferr = !s1 || (st2 && !s2);
    w.brk  = (d == '0) && (!par_on || !pb) && !s1;
    return w;
  endfunction

  task automatic build(input logic [1:0] pm, input logic st2, input logic [W-1:0] d,
                       input logic pb, input logic s1, input logic s2);
    tx_bits = {};
    tx_bits.push_back(1'b0);
    for (int i = 0; i < W; i++) tx_bits.push_back(d[i]);
    if (pm == 2'b01 || pm == 2'b10) tx_bits.push_back(pb);
    tx_bits.push_back(s1);
    if (st2) tx_bits.push_back(s2);
  endtask

  task automatic drive(input int div, input int glitch, input int cfg_at);
    int cyc = 0;
    foreach (tx_bits[b]) begin
      for (int c = 0; c < div; c++) begin
        @(negedge CLKip);
        RXi     = (cyc == glitch) ? ~tx_bits[b] : tx_bits[b];
        CFG_WEi = (cyc == cfg_at);
        cyc++;
      end
    end
    @(negedge CLKip);
    RXi     = 1'b1;
    CFG_WEi = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLKip);
      RXi = 1'b1;
    end
  endtask

  task automatic configure(input logic [15:0] div, input logic [1:0] pm, input logic st2);
    @(negedge CLKip);
    BAUD_DIVi = div; PARITY_MODEi = pm; STOP2i = st2; CFG_WEi = 1'b1;
    @(negedge CLKip);
    CFG_WEi = 1'b0;
  endtask

  task automatic wait_cnt(input int exp, input int max_cyc, input string name);
    int n = 0;
    while (int'(FIFO_CNTo) != exp && n < max_cyc) begin
      @(negedge CLKip);
      n++;
    end
    chk(name, 32'(FIFO_CNTo), 32'(exp));
  endtask

  task automatic pop_one();
    @(negedge CLKip);
    READYi = 1'b1;
    @(negedge CLKip);
    READYi = 1'b0;
  endtask

  task automatic chk_word(input string name, input word_t exp);
    chk(name, 32'({BRKo, FERRo, PERRo, DATAo}), 32'(exp));
  endtask

  initial begin
    int busy_cyc, snap;
    RSTi = 1'b1; RXi = 1'b1; CFG_WEi = 1'b0; BAUD_DIVi = 16'd16;
    PARITY_MODEi = 2'b00; STOP2i = 1'b0; READYi = 1'b0;

    vecs[0] = '{2'b01, 1'b0, 8'h37, 1'b0, 1'b1, 1'b1, 8'h37, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 1'b0, 8'h37, 1'b1, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 1'b0, 8'h37, 1'b0, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 1'b0, 8'h37, 1'b1, 1'b1, 1'b1, 8'h37, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'b00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 1'b0, 8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{2'b00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};

    // Reset values
    repeat (3) @(negedge CLKip);
    chk("rst DATAo", 32'(DATAo), 0);
    chk("rst VALIDo", 32'(VALIDo), 0);
    chk("rst PERRo", 32'(PERRo), 0);
    chk("rst FERRo", 32'(FERRo), 0);
    chk("rst BRKo", 32'(BRKo), 0);
    chk("rst OVRo", 32'(OVRo), 0);
    chk("rst BUSYo", 32'(BUSYo), 0);
    chk("rst FIFO_CNTo", 32'(FIFO_CNTo), 0);
    RSTi = 1'b0;
    idle(10);

    // Default 8N1 at the reset divisor
    build(2'b00, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
    drive(DEFD, -1, -1);
    wait_cnt(1, 4 * DEFD, "def cnt");
    chk("def VALIDo", 32'(VALIDo), 1);
    chk_word("def word", word_t'({3'b000, 8'hA5}));
    pop_one();
    chk("def VALIDo after pop", 32'(VALIDo), 0);
    chk("def cnt after pop", 32'(FIFO_CNTo), 0);

    // Directed frame table at div 16
    for (int v = 0; v < 10; v++) begin
      configure(16'd16, vecs[v].pm, vecs[v].st2);
      build(vecs[v].pm, vecs[v].st2, vecs[v].d, vecs[v].pb, vecs[v].s1, vecs[v].s2);
      drive(16, -1, -1);
      idle(32);
      wait_cnt(1, 64, $sformatf("vec%0d cnt", v));
      chk($sformatf("vec%0d data", v), 32'(DATAo), 32'(vecs[v].e_d));
      chk($sformatf("vec%0d perr", v), 32'(PERRo), 32'(vecs[v].e_perr));
      chk($sformatf("vec%0d ferr", v), 32'(FERRo), 32'(vecs[v].e_ferr));
      chk($sformatf("vec%0d brk", v), 32'(BRKo), 32'(vecs[v].e_brk));
      pop_one();
      chk($sformatf("vec%0d drained", v), 32'(VALIDo), 0);
    end

    // Break: line held low 40 bit times with two stop bits
    configure(16'd16, 2'b00, 1'b1);
    for (int i = 0; i < 640; i++) begin
      @(negedge CLKip);
      RXi = 1'b0;
    end
    idle(64);
    chk("brk cnt", 32'(FIFO_CNTo), 1);
    chk_word("brk word", word_t'({3'b110, 8'h00}));
    chk("brk idle", 32'(BUSYo), 0);
    pop_one();

    // False start: 4 low clocks, busy only until the start vote
    configure(16'd16, 2'b00, 1'b0);
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLKip);
      if (BUSYo) busy_cyc++;
      RXi = (i < 4) ? 1'b0 : 1'b1;
    end
    chk("false start busy cycles", 32'(busy_cyc == 9 || busy_cyc == 10), 1);
    chk("false start busy end", 32'(BUSYo), 0);
    chk("false start no word", 32'(FIFO_CNTo), 0);

    // Single-clock glitch at the centre of a data bit
    build(2'b00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
    drive(16, 4 * 16 + 8, -1);
    idle(32);
    wait_cnt(1, 64, "glitch cnt");
    chk_word("glitch word", word_t'({3'b000, 8'h5A}));
    pop_one();

    // Divisor below minimum clamps to 4
    configure(16'd2, 2'b00, 1'b0);
    build(2'b00, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
    drive(4, -1, -1);
    idle(16);
    wait_cnt(1, 32, "clamp cnt");
    chk_word("clamp word", word_t'({3'b000, 8'h96}));
    pop_one();

    // Overrun with READYi low, plus a config write mid-frame that must be ignored
    configure(16'd16, 2'b00, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) snap = ovr_cycles;
      build(2'b00, 1'b0, 8'(k), 1'b0, 1'b1, 1'b1);
      if (k == 3) begin
        BAUD_DIVi = 16'd100; PARITY_MODEi = 2'b01; STOP2i = 1'b1;
        drive(16, -1, 40);
        BAUD_DIVi = 16'd16; PARITY_MODEi = 2'b00; STOP2i = 1'b0;
      end else begin
        drive(16, -1, -1);
      end
      idle(32);
      if (k <= 4) wait_cnt(k, 64, $sformatf("ovr fill %0d", k));
    end
    chk("ovr none before 5th", 32'(snap), 0);
    chk("ovr one pulse", 32'(ovr_cycles - snap), 1);
    chk("ovr cnt held", 32'(FIFO_CNTo), 4);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain %0d valid", k), 32'(VALIDo), 1);
      chk($sformatf("drain %0d data", k), 32'(DATAo), 32'(k));
      pop_one();
    end
    chk("drain empty", 32'(VALIDo), 0);

    // Reset mid-DATA with two words queued
    for (int k = 0; k < 2; k++) begin
      build(2'b00, 1'b0, 8'(8'h11 * (k + 1)), 1'b0, 1'b1, 1'b1);
      drive(16, -1, -1);
      idle(32);
    end
    wait_cnt(2, 64, "rst queued");
    tx_bits = {};
    tx_bits.push_back(1'b0); tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0); tx_bits.push_back(1'b0);
    foreach (tx_bits[b]) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge CLKip);
        RXi = tx_bits[b];
      end
    end
    chk("rst mid busy", 32'(BUSYo), 1);
    RSTi = 1'b1;
    RXi  = 1'b1;
    @(negedge CLKip);
    chk("rst mid VALIDo", 32'(VALIDo), 0);
    chk("rst mid cnt", 32'(FIFO_CNTo), 0);
    chk("rst mid BUSYo", 32'(BUSYo), 0);
    RSTi = 1'b0;
    idle(20);
    build(2'b00, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1);
    drive(DEFD, -1, -1);
    wait_cnt(1, 4 * DEFD, "post rst cnt");
    chk_word("post rst word", word_t'({3'b000, 8'h3C}));
    pop_one();

    // Randomized frames against the model and a FIFO scoreboard
    exp_q = {};
    for (int r = 0; r < 14; r++) begin
      logic [15:0]  dv;
      logic [1:0]   pm;
      logic         st2, pb, s1, s2;
      logic [W-1:0] d;
      int           eff;
      dv  = 16'($urandom_range(1, 24));
      eff = (dv < 16'd4) ? 4 : int'(dv);
      pm  = 2'($urandom_range(0, 3));
      st2 = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      pb  = 1'($urandom_range(0, 1));
      s1  = 1'($urandom_range(0, 4) != 0);
      s2  = 1'($urandom_range(0, 4) != 0);
      configure(dv, pm, st2);
      build(pm, st2, d, pb, s1, s2);
      drive(eff, -1, -1);
      idle(3 * eff);
      exp_q.push_back(model(pm, d, pb, st2, s1, s2));
      wait_cnt(exp_q.size(), 8 * eff, $sformatf("rnd%0d cnt", r));
      if (exp_q.size() == DEPTH || $urandom_range(0, 1) == 1 || r == 13) begin
        while (exp_q.size() > 0) begin
          chk($sformatf("rnd%0d valid", r), 32'(VALIDo), 1);
          chk_word($sformatf("rnd%0d word", r), exp_q.pop_front());
          pop_one();
        end
        chk($sformatf("rnd%0d empty", r), 32'(VALIDo), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised next-generation UART receiver with run-time frame configuration (divisor, parity, stop bits), 3-sample majority-vote bit recovery, false-start rejection, per-word error flags, break detection and an output FIFO with valid/ready handshake. Sits between the board-level RX pin and the consumer logic, replacing the fixed 8N1 receiver where buffering and error reporting are needed.

## Interface
- FREQ_CLK, 100_000_000, clock frequency in Hz
- DATA_WDTH, 8, data bits per frame, legal 5..9
- FIFO_DEPTH, 4, output FIFO words, power of two, ≥2
- DEF_BAUD, 115200, baud after reset; default divisor DEF_DIV = FREQ_CLK/DEF_BAUD (868)

- CLKip  in  1  clock, single domain
- RSTi  in  1  synchronous active-high reset
- RXi  in  1  serial line, asynchronous; internal 2-flop synchroniser, idle high
- CFG_WEi  in  1  configuration write strobe
- BAUD_DIVi  in  16  clocks per bit
- PARITY_MODEi  in  2  00 none, 01 even, 10 odd, 11 treated as none
- STOP2i  in  1  0 one stop bit, 1 two stop bits
- READYi  in  1  consumer accepts word
- DATAo  out  DATA_WDTH  head-of-FIFO data
- VALIDo  out  1  FIFO non-empty
- PERRo  out  1  parity error flag of head word
- FERRo  out  1  framing error flag of head word
- BRKo  out  1  break flag of head word (all data 0, parity 0 if enabled, first stop 0)
- OVRo  out  1  one-cycle pulse: completed word dropped, FIFO full
- BUSYo  out  1  frame in progress (state ≠ IDLE)
- FIFO_CNTo  out  $clog2(FIFO_DEPTH+1)  words held

## Operation
- Config registers: CFG_WEi sampled each cycle; loaded only when state is IDLE, ignored otherwise. BAUD_DIVi < 4 loads as 4. Reset: div=DEF_DIV, parity none, one stop bit.
- h = div>>1. Bit counter bc runs 0..div-1 per bit period; bit k period starts at start-detect cycle + k·div. Each bit is the majority of synchronised rx at bc = h-1, h, h+1; decision at bc = h+1.
- FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE: start-detect = synchronised rx 0 with previous synced sample 1; → START, bc=0.
- START: vote = 1 → IDLE, nothing written (false start). vote = 0 → DATA.
- DATA: DATA_WDTH bits, LSB first; after last → PARITY if enabled, else STOP.
- PARITY: even: error if XOR(data, parity bit) ≠ 0; odd: error if it ≠ 1.
- STOP: one or two stop bits; any stop vote 0 sets FERR. After final stop vote → IDLE immediately (mid-bit), word written next cycle.
- Stored word = {BRK, FERR, PERR, data}. Write when FIFO full and no pop that cycle: word dropped, OVRo pulses, FIFO unchanged.
- FIFO: first-word fall-through; pop when VALIDo & READYi. Simultaneous write and pop while full: both occur, no overrun. Order preserved; pointers wrap modulo FIFO_DEPTH.
- After a framing error, IDLE requires a 1→0 transition, so a held-low line (break) produces exactly one word.
- Reset mid-frame: partial frame discarded, FIFO emptied, config to defaults.

## Timing
- Reset values: DATAo 0, VALIDo 0, PERRo 0, FERRo 0, BRKo 0, OVRo 0, BUSYo 0, FIFO_CNTo 0.
- RXi→synchronised rx: 2 cycles.
- Final stop vote at cycle T; FIFO write at T+1; VALIDo/DATAo/flags valid at T+2 if FIFO was empty; FIFO_CNTo updates at T+2.
- Pop at cycle P: next word (or VALIDo=0) visible at P+1.
- OVRo high exactly cycle T+2 of the dropped word.
- BUSYo high from cycle after start-detect until return to IDLE.

## Test plan
- Reset defaults, 8N1 at 115200 (div 868), send 0xA5 → one word DATAo=0xA5, PERRo=FERRo=BRKo=0, FIFO_CNTo=1; READYi pulse → VALIDo=0.
- CFG div=16, even parity, send 0x37 with parity bit 0 → DATAo=0x37, PERRo=1; same with parity bit 1 → PERRo=0; odd mode inverts both.
- div=16, STOP2i=1, second stop bit driven 0 → FERRo=1; line held low 40 bit times → exactly one word, DATAo=0x00, FERRo=1, BRKo=1.
- div=16, RXi low 4 clocks then high → no word, BUSYo returns 0 at start-vote; single inverted clock at bit centre of 0x5A → still 0x5A.
- FIFO_DEPTH=4, READYi=0, send 0x01..0x05 → FIFO_CNTo=4, one OVRo pulse on 5th; drain yields 0x01..0x04 in order; CFG_WEi mid-frame ignored.
- Assert RSTi mid-DATA with 2 words queued → next cycle VALIDo=0, FIFO_CNTo=0, BUSYo=0; following 0x3C frame at DEF_BAUD received correctly.
